arcade_input_conditioner: RTL and testbench
===========================================

ARCADE_INPUT_CONDITIONER -- requirements
Module: arcade_input_conditioner

Interface
REQ-001 The block SHALL take parameter NPLAYERS, default 2, number of player channels (1..4).
REQ-002 The block SHALL take parameter NBTN, default 8, buttons per player taken from joystick bits [4 +: NBTN] (1..12).
REQ-003 The block SHALL take parameter NDIP, default 8, number of DIP bytes captured (1..8).
REQ-004 The block SHALL take parameter COIN_FRAMES, default 3, coin pulse length in frames (1..15).
REQ-005 clk_53p6  in  1  sole clock; one clock, reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 joy_in  in  NPLAYERS x 16  MiSTer joystick words: bit0 right, 1 left, 2 down, 3 up, 8 coin, 9 pause, active-high.
REQ-008 vblank  in  1  video vertical blank; rising edge = frame tick.
REQ-009 shared_mode  in  1  1 = joy_in[0] drives every player channel (alternating play).
REQ-010 af_mask  in  NBTN  per-button autofire enable.
REQ-011 af_rate  in  2  autofire half-period: 0 off, 1/2/3 = 1/2/4 frames.
REQ-012 ioctl_wr, ioctl_index[7:0], ioctl_addr[24:0], ioctl_dout[7:0]  in  HPS download port.
REQ-013 dir_n  out  NPLAYERS x 4  {up,down,right,left}, active-low.
REQ-014 btn_n  out  NPLAYERS x NBTN  active-low buttons.
REQ-015 coin_n  out  NPLAYERS  active-low stretched coin pulse.
REQ-016 pause  out  1  active-high latched pause.
REQ-017 dip  out  NDIP x 8  captured DIP bytes; game  out  8  game-select byte.

Function
REQ-018 Source for player p SHALL be joy_in[0] when shared_mode=1, else joy_in[p]; dir_n/btn_n SHALL equal the inverted source one clock after sampling (latency 1).
REQ-019 Frame tick SHALL be a one-cycle pulse on the clock after vblank is sampled 0 then 1.
REQ-020 Coin FSM per player SHALL have states IDLE, PULSE, WAIT_REL: IDLE->PULSE on source bit8 rising edge; coin_n=0 only in PULSE; PULSE->WAIT_REL after COIN_FRAMES frame ticks; WAIT_REL->IDLE when bit8=0.
REQ-021 Coin pulse length SHALL be independent of hold time; presses during PULSE/WAIT_REL SHALL be ignored.
REQ-022 A frame tick coincident with PULSE entry SHALL NOT count toward COIN_FRAMES.
REQ-023 pause SHALL toggle on each rising edge of bit9 of any player source; simultaneous edges SHALL toggle once.
REQ-024 Autofire per player: when af_rate≠0 and a masked button is held, output SHALL alternate pressed/released every 2^(af_rate-1) frame ticks, starting pressed on the cycle after first press.
REQ-025 Autofire phase counter SHALL restart (pressed phase) whenever no masked button of that player is held; unmasked buttons or af_rate=0 SHALL pass through per REQ-018.
REQ-026 ioctl_wr with ioctl_index=254 and ioctl_addr<NDIP SHALL write ioctl_dout to dip[ioctl_addr] next clock; addresses ≥NDIP SHALL be ignored.
REQ-027 ioctl_wr with ioctl_index=1 and ioctl_addr=0 SHALL write game; writes without ioctl_wr SHALL have no effect.

Reset
REQ-028 Reset SHALL set dir_n, btn_n, coin_n to all-ones, pause to 0, coin FSMs to IDLE, autofire counters and edge detectors to zero (first tick after reset needs a fresh 0->1).
REQ-029 dip and game SHALL NOT be affected by reset (system reset is held during download); power-up value dip=8'hFF each, game=0.
REQ-030 Reset asserted mid-pulse SHALL force coin_n=1 the next clock; reset SHALL win over any coincident edge.
REQ-031 A coin held through reset release SHALL NOT generate a pulse until released and re-pressed.

Structure
REQ-032 Package arcade_input_pkg SHALL hold joystick bit-position constants, coin FSM state enum, af_rate encoding.
REQ-033 One sub-module input_channel SHALL implement a single player's registering, coin FSM and autofire; top instantiates NPLAYERS copies plus pause/DIP/game logic.

Verification
REQ-034 joy_in[0]=16'h0010 -> btn_n[0][0]=0 exactly one clock later; release -> 1 one clock later.
REQ-035 COIN_FRAMES=3, bit8 held 10 frames -> coin_n[0] low exactly 3 frame ticks, single pulse; re-press after release -> second pulse.
REQ-036 af_rate=2, af_mask[0]=1, button held 8 frames -> btn_n[0][0] pattern 0,0,1,1,0,0,1,1 per frame.
REQ-037 shared_mode=1, joy_in[0]=16'h0008, joy_in[1]=0 -> dir_n[0]=dir_n[1]=4'b0111.
REQ-038 index 254 writes addr 0..9 with 8'hA0+addr, NDIP=8 -> dip[0..7]=A0..A7, addr 8,9 discarded; then reset -> dip unchanged.
REQ-039 Reset during coin PULSE with bit8 still held -> coin_n=1 next clock, no pulse after reset until release/re-press.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input conditioner.
package arcade_input_pkg;

    localparam int unsigned JOY_W      = 16;
    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_BTN0   = 4;
    localparam int unsigned JOY_COIN   = 8;
    localparam int unsigned JOY_PAUSE  = 9;

    localparam int unsigned COIN_CNT_W = 4;
    localparam int unsigned AF_CNT_W   = 3;

    localparam logic [7:0] IOCTL_IDX_DIP  = 8'd254;
    localparam logic [7:0] IOCTL_IDX_GAME = 8'd1;

    typedef enum logic [1:0] {
        COIN_IDLE     = 2'd0,
        COIN_PULSE    = 2'd1,
        COIN_WAIT_REL = 2'd2
    } coin_state_t;

    typedef enum logic [1:0] {
        AF_OFF = 2'd0,
        AF_1F  = 2'd1,
        AF_2F  = 2'd2,
        AF_4F  = 2'd3
    } af_rate_t;

    // Autofire half-period in frame ticks for a given rate code.
    function automatic logic [AF_CNT_W-1:0] af_half_period(input logic [1:0] rate);
        case (af_rate_t'(rate))
            AF_1F:   return AF_CNT_W'(1);
            AF_2F:   return AF_CNT_W'(2);
            AF_4F:   return AF_CNT_W'(4);
            default: return AF_CNT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/arcade_input_conditioner_input_channel.sv
// One player channel: registered directions/buttons, coin pulse stretcher, autofire.
module input_channel
    import arcade_input_pkg::*;
#(
    parameter int unsigned NBTN        = 8,
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic              clk_53p6,
    input  logic              reset,
    input  logic [JOY_W-1:0]  src,
    input  logic              frame_tick,
    input  logic [NBTN-1:0]   af_mask,
    input  logic [1:0]        af_rate,
    output logic [3:0]        dir_n,
    output logic [NBTN-1:0]   btn_n,
    output logic              coin_n
);

    logic [NBTN-1:0]       btn_src;
    logic                  coin_src;
    logic                  coin_prev;
    coin_state_t           coin_state;
    logic [COIN_CNT_W-1:0] coin_cnt;
    logic [NBTN-1:0]       af_mask_eff;
    logic                  af_held;
    logic [AF_CNT_W-1:0]   af_cnt;
    logic [AF_CNT_W-1:0]   af_cnt_d;
    logic                  af_phase;
    logic                  af_phase_d;
    logic                  unused_src;

    assign btn_src    = src[JOY_BTN0 +: NBTN];
    assign coin_src   = src[JOY_COIN];
    assign unused_src = ^src;

    // Autofire phase: restarts in the pressed phase whenever no masked button is held.
    always_comb begin
        af_mask_eff = (af_rate_t'(af_rate) != AF_OFF) ? af_mask : '0;
        af_held     = |(btn_src & af_mask_eff);
        af_cnt_d    = af_cnt;
        af_phase_d  = af_phase;
        if (!af_held) begin
            af_cnt_d   = '0;
            af_phase_d = 1'b0;
        end else if (frame_tick) begin
            if (af_cnt + AF_CNT_W'(1) == af_half_period(af_rate)) begin
                af_cnt_d   = '0;
                af_phase_d = ~af_phase;
            end else begin
                af_cnt_d = af_cnt + AF_CNT_W'(1);
            end
        end
    end

    // Registered direction/button outputs; masked buttons are released in the off phase.
    always_ff @(posedge clk_53p6) begin
        if (reset) begin
            dir_n    <= '1;
            btn_n    <= '1;
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else begin
            dir_n    <= ~{src[JOY_UP], src[JOY_DOWN], src[JOY_RIGHT], src[JOY_LEFT]};
            btn_n    <= ~(btn_src & ~(af_mask_eff & {NBTN{af_phase_d}}));
            af_cnt   <= af_cnt_d;
            af_phase <= af_phase_d;
        end
    end

    // Coin FSM: fixed-length pulse per press; a coin held through reset must be released first.
    always_ff @(posedge clk_53p6) begin
        if (reset) begin
            coin_state <= COIN_IDLE;
            coin_cnt   <= '0;
            coin_n     <= 1'b1;
            coin_prev  <= 1'b1;
        end else begin
            coin_prev <= coin_src;
            case (coin_state)
                COIN_IDLE: begin
                    coin_n <= 1'b1;
                    if (coin_src && !coin_prev) begin
                        coin_state <= COIN_PULSE;
                        coin_cnt   <= '0;
                        coin_n     <= 1'b0;
                    end
                end
                COIN_PULSE: begin
                    if (frame_tick) begin
                        if (coin_cnt == COIN_CNT_W'(COIN_FRAMES - 1)) begin
                            coin_state <= COIN_WAIT_REL;
                            coin_cnt   <= '0;
                            coin_n     <= 1'b1;
                        end else begin
                            coin_cnt <= coin_cnt + COIN_CNT_W'(1);
                        end
                    end
                end
                COIN_WAIT_REL: begin
                    coin_n <= 1'b1;
                    if (!coin_src) begin
                        coin_state <= COIN_IDLE;
                    end
                end
                default: begin
                    coin_state <= COIN_IDLE;
                    coin_n     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_conditioner.sv
// Arcade input conditioner: per-player channels, frame tick, pause toggle, DIP/game capture.
module arcade_input_conditioner
    import arcade_input_pkg::*;
#(
    parameter int unsigned NPLAYERS    = 2,
    parameter int unsigned NBTN        = 8,
    parameter int unsigned NDIP        = 8,
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic                             clk_53p6,
    input  logic                             reset,
    input  logic [NPLAYERS-1:0][JOY_W-1:0]   joy_in,
    input  logic                             vblank,
    input  logic                             shared_mode,
    input  logic [NBTN-1:0]                  af_mask,
    input  logic [1:0]                       af_rate,
    input  logic                             ioctl_wr,
    input  logic [7:0]                       ioctl_index,
    input  logic [24:0]                      ioctl_addr,
    input  logic [7:0]                       ioctl_dout,
    output logic [NPLAYERS-1:0][3:0]         dir_n,
    output logic [NPLAYERS-1:0][NBTN-1:0]    btn_n,
    output logic [NPLAYERS-1:0]              coin_n,
    output logic                             pause,
    output logic [NDIP-1:0][7:0]             dip,
    output logic [7:0]                       game
);

    logic [NPLAYERS-1:0][JOY_W-1:0] src;
    logic [NPLAYERS-1:0]            pause_src;
    logic [NPLAYERS-1:0]            pause_prev;
    logic                           vblank_prev;
    logic                           frame_tick;
    // Download-captured settings keep their power-up value until written; reset leaves them alone.
    logic [NDIP-1:0][7:0]           dip_q  = '1;
    logic [7:0]                     game_q = '0;

    assign dip  = dip_q;
    assign game = game_q;

    // Player source select: shared mode feeds player 0's stick to every channel.
    always_comb begin
        for (int unsigned p = 0; p < NPLAYERS; p++) begin
            src[p]       = shared_mode ? joy_in[0] : joy_in[p];
            pause_src[p] = src[p][JOY_PAUSE];
        end
    end

    // Frame tick on vblank rise; the detector is primed high so reset needs a fresh 0->1.
    always_ff @(posedge clk_53p6) begin
        if (reset) begin
            vblank_prev <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            vblank_prev <= vblank;
            frame_tick  <= vblank & ~vblank_prev;
        end
    end

    // Pause toggles once per cycle in which any player's pause bit rises.
    always_ff @(posedge clk_53p6) begin
        if (reset) begin
            pause_prev <= '1;
            pause      <= 1'b0;
        end else begin
            pause_prev <= pause_src;
            if (|(pause_src & ~pause_prev)) begin
                pause <= ~pause;
            end
        end
    end

    // HPS download capture of DIP bytes and game-select byte.
    always_ff @(posedge clk_53p6) begin
        if (ioctl_wr && ioctl_index == IOCTL_IDX_DIP) begin
            for (int unsigned i = 0; i < NDIP; i++) begin
                if (ioctl_addr == 25'(i)) begin
                    dip_q[i] <= ioctl_dout;
                end
            end
        end
        if (ioctl_wr && ioctl_index == IOCTL_IDX_GAME && ioctl_addr == 25'd0) begin
            game_q <= ioctl_dout;
        end
    end

    // One conditioning channel per player.
    for (genvar p = 0; p < NPLAYERS; p++) begin : g_ch
        input_channel #(
            .NBTN        (NBTN),
            .COIN_FRAMES (COIN_FRAMES)
        ) u_ch (
            .clk_53p6   (clk_53p6),
            .reset      (reset),
            .src        (src[p]),
            .frame_tick (frame_tick),
            .af_mask    (af_mask),
            .af_rate    (af_rate),
            .dir_n      (dir_n[p]),
            .btn_n      (btn_n[p]),
            .coin_n     (coin_n[p])
        );
    end

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed self-checking bench for arcade_input_conditioner (NPLAYERS=2, NBTN=8, NDIP=8, COIN_FRAMES=3).
module tb_arcade_input_conditioner;

    logic             clk_53p6;
    logic             reset;
    logic [1:0][15:0] joy_in;
    logic             vblank;
    logic             shared_mode;
    logic [7:0]       af_mask;
    logic [1:0]       af_rate;
    logic             ioctl_wr;
    logic [7:0]       ioctl_index;
    logic [24:0]      ioctl_addr;
    logic [7:0]       ioctl_dout;
    logic [1:0][3:0]  dir_n;
    logic [1:0][7:0]  btn_n;
    logic [1:0]       coin_n;
    logic             pause;
    logic [7:0][7:0]  dip;
    logic [7:0]       game;

    int tests_run    = 0;
    int tests_failed = 0;
    int low_cnt      = 0;
    int pulse_cnt    = 0;
    logic prev_coin  = 1'b1;
    logic af_obs [8];
    logic af_exp [8];

    arcade_input_conditioner #(
        .NPLAYERS    (2),
        .NBTN        (8),
        .NDIP        (8),
        .COIN_FRAMES (3)
    ) dut (
        .clk_53p6    (clk_53p6),
        .reset       (reset),
        .joy_in      (joy_in),
        .vblank      (vblank),
        .shared_mode (shared_mode),
        .af_mask     (af_mask),
        .af_rate     (af_rate),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .dir_n       (dir_n),
        .btn_n       (btn_n),
        .coin_n      (coin_n),
        .pause       (pause),
        .dip         (dip),
        .game        (game)
    );

    initial begin
        clk_53p6 = 1'b0;
        forever #5 clk_53p6 = ~clk_53p6;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock, settle, and track player-0 coin pulses.
    task automatic step();
        @(posedge clk_53p6);
        #1;
        if (coin_n[0] == 1'b0) low_cnt++;
        if (prev_coin == 1'b1 && coin_n[0] == 1'b0) pulse_cnt++;
        prev_coin = coin_n[0];
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One 8-clock frame with vblank high for the first clock.
    task automatic frame();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        steps(7);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        joy_in      = '0;
        vblank      = 1'b0;
        shared_mode = 1'b0;
        af_mask     = '0;
        af_rate     = 2'd0;
        ioctl_wr    = 1'b0;
        ioctl_index = '0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        af_exp      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state and power-up download values
        steps(3);
        check("rst_dir_n", 64'(dir_n), 64'h00FF);
        check("rst_btn_n", 64'(btn_n), 64'hFFFF);
        check("rst_coin_n", 64'(coin_n), 64'h3);
        check("rst_pause", 64'(pause), 64'h0);
        check("pwrup_dip", 64'(dip), 64'hFFFF_FFFF_FFFF_FFFF);
        check("pwrup_game", 64'(game), 64'h00);
        reset = 1'b0;
        step();

        // Button latency of exactly one clock
        joy_in[0] = 16'h0010;
        check("btn_before_edge", 64'(btn_n[0]), 64'hFF);
        step();
        check("btn_press_lat1", 64'(btn_n[0]), 64'hFE);
        joy_in[0] = 16'h0000;
        step();
        check("btn_release_lat1", 64'(btn_n[0]), 64'hFF);

        // Shared mode mirrors player 0, independent mode uses each stick
        shared_mode = 1'b1;
        joy_in[0]   = 16'h0008;
        joy_in[1]   = 16'h0000;
        step();
        check("shared_dir0", 64'(dir_n[0]), 64'h7);
        check("shared_dir1", 64'(dir_n[1]), 64'h7);
        shared_mode = 1'b0;
        joy_in[1]   = 16'h0001;
        step();
        check("indep_dir0", 64'(dir_n[0]), 64'h7);
        check("indep_dir1_right", 64'(dir_n[1]), 64'hD);
        joy_in = '0;
        step();

        // Pause: simultaneous edges toggle once, a later single edge toggles back
        joy_in[0] = 16'h0200;
        joy_in[1] = 16'h0200;
        step();
        check("pause_dual_edge", 64'(pause), 64'h1);
        joy_in = '0;
        step();
        check("pause_hold", 64'(pause), 64'h1);
        joy_in[1] = 16'h0200;
        step();
        check("pause_toggle_back", 64'(pause), 64'h0);
        joy_in = '0;
        steps(2);

        // Coin pressed on the tick-consume clock: that tick is not counted, pulse = 3 frames
        vblank = 1'b1;
        step();
        vblank    = 1'b0;
        joy_in[0] = 16'h0100;
        low_cnt   = 0;
        pulse_cnt = 0;
        step();
        check("coin_start", 64'(coin_n[0]), 64'h0);
        steps(6);
        for (int f = 0; f < 9; f++) frame();
        check("coin_low_cycles", 64'(low_cnt), 64'd24);
        check("coin_single_pulse", 64'(pulse_cnt), 64'd1);
        check("coin_p1_idle", 64'(coin_n[1]), 64'h1);

        // Release and re-press: second pulse, press not aligned to a tick
        joy_in[0] = 16'h0000;
        steps(2);
        low_cnt   = 0;
        pulse_cnt = 0;
        joy_in[0] = 16'h0100;
        for (int f = 0; f < 4; f++) frame();
        check("coin2_pulse", 64'(pulse_cnt), 64'd1);
        check("coin2_low_cycles", 64'(low_cnt), 64'd17);
        check("coin2_end", 64'(coin_n[0]), 64'h1);
        joy_in[0] = 16'h0000;
        steps(2);

        // Reset mid-pulse with coin still held
        joy_in[0] = 16'h0100;
        step();
        check("coin_rst_pre", 64'(coin_n[0]), 64'h0);
        reset = 1'b1;
        step();
        check("coin_rst_forced_high", 64'(coin_n[0]), 64'h1);
        step();
        reset     = 1'b0;
        low_cnt   = 0;
        pulse_cnt = 0;
        steps(3);
        for (int f = 0; f < 2; f++) frame();
        check("coin_held_thru_rst", 64'(low_cnt), 64'd0);
        joy_in[0] = 16'h0000;
        step();
        joy_in[0] = 16'h0100;
        step();
        check("coin_repress_after_rst", 64'(coin_n[0]), 64'h0);
        for (int f = 0; f < 4; f++) frame();
        joy_in[0] = 16'h0000;
        steps(2);

        // Autofire at 2-frame half period, button 0 masked, button 1 unmasked
        af_rate   = 2'd2;
        af_mask   = 8'h01;
        joy_in[0] = 16'h0030;
        for (int k = 0; k < 8; k++) begin
            vblank = 1'b1;
            step();
            af_obs[k] = btn_n[0][0];
            vblank = 1'b0;
            steps(7);
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("af_frame%0d", k), 64'(af_obs[k]), 64'(af_exp[k]));
        end
        check("af_unmasked_steady", 64'(btn_n[0][1]), 64'h0);
        joy_in[0] = 16'h0000;
        step();
        check("af_release", 64'(btn_n[0]), 64'hFF);
        joy_in[0] = 16'h0010;
        step();
        check("af_restart_pressed", 64'(btn_n[0]), 64'hFE);
        joy_in[0] = 16'h0000;
        af_rate   = 2'd0;
        af_mask   = '0;
        step();

        // DIP capture, out-of-range addresses dropped
        ioctl_index = 8'd254;
        for (int a = 0; a < 10; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(a);
            ioctl_dout = 8'hA0 + 8'(a);
            step();
            ioctl_wr = 1'b0;
            step();
        end
        check("dip_capture", 64'(dip), 64'hA7A6_A5A4_A3A2_A1A0);

        // Game byte: no effect without ioctl_wr, captured with it
        ioctl_index = 8'd1;
        ioctl_addr  = 25'd0;
        ioctl_dout  = 8'h55;
        step();
        check("game_no_wr", 64'(game), 64'h00);
        ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        step();
        check("game_write", 64'(game), 64'h55);

        // Reset does not disturb captured settings
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        step();
        check("dip_after_rst", 64'(dip), 64'hA7A6_A5A4_A3A2_A1A0);
        check("game_after_rst", 64'(game), 64'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
